arb2x1_rr: RTL and testbench
============================

ARB2X1_RR -- requirements
Module: arb2x1_rr

Interface
REQ-001 Parameter W, default 8, width of each data beat.
REQ-002 Parameter MAX_BEATS, default 4, max beats per grant (>=1).
REQ-003 Port clk  input  1  rising-edge clock, the block's only clock.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req_valid  input  2  per-requester valid, bit i = requester i.
REQ-006 Port req_data  input  2*W  requester i data in bits [i*W +: W].
REQ-007 Port req_last  input  2  per-requester end-of-burst marker.
REQ-008 Port req_ready  output  2  per-requester ready.
REQ-009 Port out_valid  output  1  shared channel valid.
REQ-010 Port out_data  output  W  shared channel data.
REQ-011 Port out_last  output  1  shared channel end-of-burst.
REQ-012 Port out_ready  input  1  downstream ready.
REQ-013 Port grant  output  2  one-hot current grant, 2'b00 when idle.
REQ-014 Port sel  output  1  registered select driving the datapath mux.

Function
REQ-015 FSM SHALL have two states: IDLE and BUSY.
REQ-016 In IDLE: out_valid, out_last, req_ready, grant SHALL be 0; sel SHALL hold its last value.
REQ-017 In IDLE, if exactly one req_valid is set, that requester SHALL be granted at the next edge.
REQ-018 In IDLE, if both are set, the requester not equal to rr_last (last served) SHALL be granted at the next edge.
REQ-019 Arbitration latency SHALL be exactly one cycle: req_valid seen in IDLE -> grant/sel valid and state BUSY on the next cycle.
REQ-020 In BUSY: out_valid = req_valid[sel], out_data = req_data[sel], req_ready[sel] = out_ready, req_ready[~sel] = 0 (combinational through the mux).
REQ-021 A beat SHALL transfer when out_valid && out_ready in BUSY.
REQ-022 beat_cnt SHALL count transferred beats, width $clog2(MAX_BEATS) (min 1), cleared on entering IDLE.
REQ-023 out_last SHALL equal req_last[sel] OR (beat_cnt == MAX_BEATS-1), gated by BUSY.
REQ-024 On a transferred beat with out_last=1: state -> IDLE, rr_last <= sel, beat_cnt <= 0.
REQ-025 sel and grant SHALL NOT change while BUSY.
REQ-026 A granted requester dropping req_valid mid-burst SHALL keep the grant; out_valid=0, no timeout.
REQ-027 out_ready=0 SHALL stall: beat_cnt, state, sel unchanged; no beat counted.
REQ-028 MAX_BEATS=1: every beat SHALL be out_last.
REQ-029 Bursts SHALL always be separated by one IDLE cycle (no back-to-back grant).

Reset
REQ-030 On rst_n=0 (asynchronously): state=IDLE, sel=0, grant=0, beat_cnt=0, rr_last=1 (requester 0 wins the first tie); all outputs 0 while reset is held.
REQ-031 Reset mid-burst SHALL abort the burst with no beat completion; after release the block SHALL arbitrate afresh from IDLE.

Structure
REQ-032 FSM state encodings (IDLE=1'b0, BUSY=1'b1) SHALL live in a shared package file arb_pkg for reuse by future N-way arbiters.
REQ-033 The W-bit data/last select SHALL be a sub-module mux2_w (W-bit 2:1 mux, select = sel); the FSM and counters stay in arb2x1_rr.

Verification (W=8, MAX_BEATS=4)
REQ-034 Reset: rst_n=0 mid-operation -> same cycle grant=00, out_valid=0, req_ready=00; sel=0 after release.
REQ-035 Single burst: req0 valid with 8'hA1, 8'hA2 (last on A2), out_ready=1 -> grant=01 one cycle later, out_data A1 then A2, out_last on A2, IDLE next cycle.
REQ-036 Contention: both valid continuously, single-beat bursts (last=1) -> grant sequence 01, 00, 10, 00, 01, ...
REQ-037 Forced release: req1 streams 6 beats, no last -> out_last on 4th beat, grant drops, req1 regranted after one IDLE cycle for the remaining 2 beats (if req0 idle).
REQ-038 Stall: out_ready=0 for 3 cycles mid-burst at beat 8'h55 -> out_data holds 8'h55, req_ready[sel]=0, beat_cnt unchanged; resumes when out_ready=1.
REQ-039 Valid gap: req0 drops valid for 2 cycles mid-burst while req1 valid -> grant stays 01, out_valid=0, req1 not served until req0 last beat.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encoding and sizing helpers,
// kept separate so wider N-way arbiters can reuse them.
package arb_pkg;

    // Arbiter FSM states; encodings are fixed for reuse across arbiters
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Beat counter width: enough to hold MAX_BEATS-1, never narrower than 1
    function automatic int unsigned cnt_width(input int unsigned max_beats);
        return (max_beats > 1) ? $clog2(max_beats) : 1;
    endfunction

    // One-hot grant vector for a two-way select
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mux2_w.sv
// W-bit 2:1 multiplexer used for the arbiter's shared-channel datapath.
module mux2_w #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/arb2x1_rr.sv
// Two-requester round-robin burst arbiter onto one shared channel.
// A grant is held for a whole burst (ended by req_last or MAX_BEATS beats),
// and bursts are always separated by one IDLE cycle.
module arb2x1_rr
    import arb_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    input  logic [2*W-1:0] req_data,
    input  logic [1:0]     req_last,
    output logic [1:0]     req_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic [1:0]     grant,
    output logic           sel
);

    localparam int unsigned CW = cnt_width(MAX_BEATS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

    arb_state_t    state, state_nxt;
    logic          sel_nxt;
    logic          rr_last, rr_last_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;

    logic [W-1:0]  mux_data;
    logic [1:0]    mux_ctrl;   // {valid, last} of the selected requester
    logic          beat_xfer;

    // Datapath select for the selected requester's data beat
    mux2_w #(
        .W(W)
    ) u_data_mux (
        .sel(sel),
        .in0(req_data[W-1:0]),
        .in1(req_data[2*W-1:W]),
        .out(mux_data)
    );

    // Same select applied to the per-requester valid/last sideband
    mux2_w #(
        .W(2)
    ) u_ctrl_mux (
        .sel(sel),
        .in0({req_valid[0], req_last[0]}),
        .in1({req_valid[1], req_last[1]}),
        .out(mux_ctrl)
    );

    // State, select, round-robin pointer and beat counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 1'b0;
            rr_last  <= 1'b1;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            rr_last  <= rr_last_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Next-state arbitration and shared-channel outputs
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        rr_last_nxt  = rr_last;
        beat_cnt_nxt = beat_cnt;
        req_ready    = 2'b00;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        grant        = 2'b00;
        beat_xfer    = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    state_nxt    = BUSY;
                    // On a tie the requester not served last wins
                    sel_nxt      = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
                    beat_cnt_nxt = '0;
                end
            end
            BUSY: begin
                grant     = onehot2(sel);
                out_valid = mux_ctrl[1];
                out_data  = mux_data;
                out_last  = mux_ctrl[0] | (beat_cnt == CNT_LAST);
                req_ready = out_ready ? onehot2(sel) : 2'b00;
                beat_xfer = out_valid & out_ready;
                if (beat_xfer) begin
                    if (out_last) begin
                        state_nxt    = IDLE;
                        rr_last_nxt  = sel;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_arb2x1_rr.sv
// Directed bench for arb2x1_rr with a per-cycle behavioural reference model
// and hand-computed expectations for each scenario.
module tb_arb2x1_rr;

    localparam int W    = 8;
    localparam int MAXB = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid = 2'b00;
    logic [2*W-1:0] req_data = '0;
    logic [1:0]     req_last = 2'b00;
    logic [1:0]     req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready = 1'b1;
    logic [1:0]     grant;
    logic           sel;

    int n_checks = 0;
    int n_fail   = 0;

    arb2x1_rr #(
        .W(W),
        .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last),
        .out_ready(out_ready),
        .grant(grant),
        .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the channel, beats moved, who was served last
    int   m_owner       = -1;
    int   m_beats       = 0;
    int   m_last_served = 1;
    logic m_sel         = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner       = -1;
            m_beats       = 0;
            m_last_served = 1;
            m_sel         = 1'b0;
        end else if (m_owner < 0) begin
            if (req_valid == 2'b11)
                m_owner = 1 - m_last_served;
            else if (req_valid != 2'b00)
                m_owner = req_valid[1] ? 1 : 0;
            if (m_owner >= 0) begin
                m_sel   = (m_owner == 1);
                m_beats = 0;
            end
        end else if (req_valid[m_owner] && out_ready) begin
            if (req_last[m_owner] || m_beats == MAXB - 1) begin
                m_last_served = m_owner;
                m_owner       = -1;
                m_beats       = 0;
            end else begin
                m_beats++;
            end
        end
    end

    logic [1:0]   e_grant, e_ready;
    logic         e_valid, e_last;
    logic [W-1:0] e_data;

    // Every falling edge: DUT outputs against the model
    always @(negedge clk) begin
        if (m_owner >= 0) begin
            e_grant = 2'(1 << m_owner);
            e_valid = req_valid[m_owner];
            e_data  = req_data[m_owner*W +: W];
            e_last  = req_last[m_owner] || (m_beats == MAXB - 1);
            e_ready = out_ready ? 2'(1 << m_owner) : 2'b00;
        end else begin
            e_grant = 2'b00;
            e_valid = 1'b0;
            e_data  = '0;
            e_last  = 1'b0;
            e_ready = 2'b00;
        end
        chk("model_grant", grant, e_grant);
        chk("model_out_valid", out_valid, e_valid);
        chk("model_out_data", out_data, e_data);
        chk("model_out_last", out_last, e_last);
        chk("model_req_ready", req_ready, e_ready);
        chk("model_sel", sel, m_sel);
    end

    logic [1:0] g36 [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [1:0] g37 [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00};
    logic       l37 [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int idx;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        chk("reset_grant", grant, 2'b00);
        chk("reset_sel", sel, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);

        // Single burst from requester 0: A1, A2(last)
        req_valid = 2'b01; req_data[7:0] = 8'hA1; req_last = 2'b00;
        step(); #1;
        chk("s1_grant", grant, 2'b01);
        chk("s1_data_a1", out_data, 8'hA1);
        chk("s1_last_a1", out_last, 1'b0);
        step();
        req_data[7:0] = 8'hA2; req_last = 2'b01;
        #1;
        chk("s1_data_a2", out_data, 8'hA2);
        chk("s1_last_a2", out_last, 1'b1);
        step();
        req_valid = 2'b00; req_last = 2'b00;
        #1;
        chk("s1_idle_grant", grant, 2'b00);
        chk("s1_idle_valid", out_valid, 1'b0);

        // Reset in the middle of a requester-1 burst
        req_valid = 2'b10; req_data[15:8] = 8'hC0;
        step(); #1;
        chk("rst_pre_grant", grant, 2'b10);
        chk("rst_pre_sel", sel, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        req_valid = 2'b00;
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst_post_sel", sel, 1'b0);

        // Contention with single-beat bursts: strict alternation with idle gaps
        req_valid = 2'b11; req_last = 2'b11; req_data = {8'hD1, 8'hD0};
        for (int k = 0; k < 5; k++) begin
            step(); #1;
            chk("rr_grant", grant, g36[k]);
            if (g36[k] == 2'b01) chk("rr_data0", out_data, 8'hD0);
            if (g36[k] == 2'b10) chk("rr_data1", out_data, 8'hD1);
        end
        step();
        req_valid = 2'b00; req_last = 2'b00;

        // Forced release after MAX_BEATS, then regrant for the rest
        idx = 0;
        req_valid = 2'b10; req_data[15:8] = 8'hB0;
        for (int k = 0; k < 8; k++) begin
            step();
            req_data[15:8] = 8'(8'hB0 + idx);
            req_last[1]    = (idx == 5);
            #1;
            chk("force_grant", grant, g37[k]);
            if (g37[k] != 2'b00) begin
                chk("force_data", out_data, 8'(8'hB0 + idx));
                chk("force_last", out_last, l37[k]);
                idx++;
            end
        end
        req_valid = 2'b00; req_last = 2'b00;

        // Stall on beat 55 for three cycles; counter must not advance
        step();
        req_valid = 2'b01; req_data[7:0] = 8'h54;
        step(); #1;
        chk("stall_grant", grant, 2'b01);
        chk("stall_data54", out_data, 8'h54);
        step();
        req_data[7:0] = 8'h55; out_ready = 1'b0;
        #1;
        chk("stall_hold_data", out_data, 8'h55);
        chk("stall_ready", req_ready, 2'b00);
        repeat (2) begin
            step(); #1;
            chk("stall_hold_data", out_data, 8'h55);
            chk("stall_ready", req_ready, 2'b00);
            chk("stall_last", out_last, 1'b0);
        end
        step();
        out_ready = 1'b1;
        #1;
        chk("stall_resume_ready", req_ready, 2'b01);
        chk("stall_resume_last", out_last, 1'b0);
        step();
        req_data[7:0] = 8'h56;
        #1;
        chk("stall_last56", out_last, 1'b0);
        step();
        req_data[7:0] = 8'h57;
        #1;
        chk("stall_last57", out_last, 1'b1);
        step();
        req_valid = 2'b00;
        #1;
        chk("stall_idle", grant, 2'b00);

        // Granted requester drops valid while the other waits
        req_valid = 2'b01; req_data = {8'hE0, 8'h70}; req_last = 2'b00;
        step(); #1;
        chk("gap_grant", grant, 2'b01);
        req_valid = 2'b11; req_last = 2'b10;
        repeat (2) begin
            step();
            req_valid = 2'b10;
            #1;
            chk("gap_hold_grant", grant, 2'b01);
            chk("gap_out_valid", out_valid, 1'b0);
            chk("gap_req_ready", req_ready, 2'b01);
        end
        step();
        req_valid = 2'b11; req_data[7:0] = 8'h71; req_last = 2'b11;
        #1;
        chk("gap_resume_data", out_data, 8'h71);
        chk("gap_resume_last", out_last, 1'b1);
        step();
        req_valid = 2'b10;
        #1;
        chk("gap_idle", grant, 2'b00);
        step(); #1;
        chk("gap_req1_grant", grant, 2'b10);
        chk("gap_req1_data", out_data, 8'hE0);
        step();
        req_valid = 2'b00; req_last = 2'b00;
        #1;
        chk("gap_final_idle", grant, 2'b00);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
